// File: rtl/game_flow_ctrl.sv
// Game-phase sequencer: title, play, pause, death and win phases.
// Ports: Clk/Reset, frame_clk, keycode, dead/door flags -> revive,
//   gated keycode/frame clock, game_state, overlay_sel, death_count,
//   level_complete.
module game_flow_ctrl #(
  parameter int unsigned DEATH_FRAMES = 60,
  parameter int unsigned WIN_FRAMES   = 120,
  parameter logic [7:0]  START_KEY    = 8'h28,
  parameter logic [7:0]  PAUSE_KEY    = 8'h29
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       fireboy_dead,
  input  logic       icegirl_dead,
  input  logic       fireboy_at_door,
  input  logic       icegirl_at_door,
  output logic       revive,
  output logic [7:0] keycode_gated,
  output logic       frame_clk_gated,
  output logic [2:0] game_state,
  output logic [1:0] overlay_sel,
  output logic [7:0] death_count,
  output logic       level_complete
);

  typedef enum logic [2:0] {
    S_TITLE = 3'd0,
    S_START = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_DYING = 3'd4,
    S_WIN   = 3'd5
  } state_t;

  localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] WIN_LAST   = 8'(WIN_FRAMES - 1);

  state_t     state;
  logic [7:0] timer;
  logic [7:0] prev_key;
  logic       fclk_d;
  logic       frame_tick;

  logic start_press;
  logic pause_press;
  logic any_dead;
  logic both_door;

  // A held key only counts on the cycle it first appears.
  assign start_press = (keycode == START_KEY) &&
                       (prev_key != START_KEY);
  assign pause_press = (keycode == PAUSE_KEY) &&
                       (prev_key != PAUSE_KEY);
  assign any_dead    = fireboy_dead | icegirl_dead;
  assign both_door   = fireboy_at_door & icegirl_at_door;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= S_TITLE;
      timer          <= 8'd0;
      prev_key       <= 8'd0;
      fclk_d         <= 1'b0;
      frame_tick     <= 1'b0;
      death_count    <= 8'd0;
      level_complete <= 1'b0;
    end else begin
      prev_key       <= keycode;
      fclk_d         <= frame_clk;
      frame_tick     <= frame_clk & ~fclk_d;
      level_complete <= 1'b0;
      unique case (state)
        S_TITLE: begin
          if (start_press)
            state <= S_START;
        end
        S_START: begin
          state <= S_PLAY;
        end
        S_PLAY: begin
          // Death outranks door arrival, which outranks pause.
          if (any_dead) begin
            state <= S_DYING;
            timer <= 8'd0;
            if (death_count != 8'hFF)
              death_count <= death_count + 8'd1;
          end else if (both_door) begin
            state          <= S_WIN;
            timer          <= 8'd0;
            level_complete <= 1'b1;
          end else if (pause_press) begin
            state <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (pause_press)
            state <= S_PLAY;
        end
        S_DYING: begin
          if (frame_tick) begin
            if (timer == DEATH_LAST)
              state <= S_START;
            else
              timer <= timer + 8'd1;
          end
        end
        S_WIN: begin
          if (frame_tick) begin
            if (timer == WIN_LAST)
              state <= S_TITLE;
            else
              timer <= timer + 8'd1;
          end
        end
        default: begin
          state <= S_TITLE;
        end
      endcase
    end
  end

  assign game_state = state;

  always_comb begin
    revive          = 1'b1;
    keycode_gated   = 8'd0;
    frame_clk_gated = 1'b0;
    overlay_sel     = 2'd1;
    unique case (state)
      S_TITLE: begin
        revive      = 1'b1;
        overlay_sel = 2'd1;
      end
      S_START: begin
        revive      = 1'b1;
        overlay_sel = 2'd0;
      end
      S_PLAY: begin
        revive          = 1'b0;
        keycode_gated   = keycode;
        frame_clk_gated = frame_clk;
        overlay_sel     = 2'd0;
      end
      S_PAUSE: begin
        revive      = 1'b0;
        overlay_sel = 2'd2;
      end
      S_DYING, S_WIN: begin
        // Players keep animating under the end banner.
        revive          = 1'b0;
        frame_clk_gated = frame_clk;
        overlay_sel     = 2'd3;
      end
      default: begin
        revive      = 1'b1;
        overlay_sel = 2'd1;
      end
    endcase
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with an expected-value queue.
// Small frame counts keep the death/win phases short.
module tb_game_flow_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic [7:0] keycode;
  logic       fireboy_dead;
  logic       icegirl_dead;
  logic       fireboy_at_door;
  logic       icegirl_at_door;
  logic       revive;
  logic [7:0] keycode_gated;
  logic       frame_clk_gated;
  logic [2:0] game_state;
  logic [1:0] overlay_sel;
  logic [7:0] death_count;
  logic       level_complete;

  int checks = 0;
  int failures = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  game_flow_ctrl #(
    .DEATH_FRAMES(3),
    .WIN_FRAMES(2),
    .START_KEY(8'h28),
    .PAUSE_KEY(8'h29)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .frame_clk(frame_clk),
    .keycode(keycode),
    .fireboy_dead(fireboy_dead),
    .icegirl_dead(icegirl_dead),
    .fireboy_at_door(fireboy_at_door),
    .icegirl_at_door(icegirl_at_door),
    .revive(revive),
    .keycode_gated(keycode_gated),
    .frame_clk_gated(frame_clk_gated),
    .game_state(game_state),
    .overlay_sel(overlay_sel),
    .death_count(death_count),
    .level_complete(level_complete)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_v(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  task automatic fpulse();
    frame_clk = 1'b1;
    step();
    step();
    frame_clk = 1'b0;
    step();
    step();
  endtask

  task automatic wait_state(input logic [2:0] s, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (game_state == s) break;
      step();
    end
  endtask

  task automatic die_once();
    fireboy_dead = 1'b1;
    step();
    fireboy_dead = 1'b0;
    repeat (3) fpulse();
    wait_state(3'd2, 8);
    expect_v("die_loop_play", 32'd2);
    check(32'(game_state));
  endtask

  int cnt;

  initial begin
    Reset = 1'b1;
    frame_clk = 1'b0;
    keycode = 8'd0;
    fireboy_dead = 1'b0;
    icegirl_dead = 1'b0;
    fireboy_at_door = 1'b0;
    icegirl_at_door = 1'b0;
    step();
    step();
    expect_v("rst_state", 32'd0);
    expect_v("rst_revive", 32'd1);
    expect_v("rst_overlay", 32'd1);
    expect_v("rst_deaths", 32'd0);
    expect_v("rst_lc", 32'd0);
    expect_v("rst_kg", 32'd0);
    check(32'(game_state));
    check(32'(revive));
    check(32'(overlay_sel));
    check(32'(death_count));
    check(32'(level_complete));
    check(32'(keycode_gated));
    Reset = 1'b0;
    step();

    // Start key held for 10 cycles.
    keycode = 8'h28;
    step();
    expect_v("start_state", 32'd1);
    expect_v("start_revive", 32'd1);
    expect_v("start_overlay", 32'd0);
    check(32'(game_state));
    check(32'(revive));
    check(32'(overlay_sel));
    step();
    expect_v("play_state", 32'd2);
    expect_v("play_revive", 32'd0);
    expect_v("play_kg", 32'h28);
    check(32'(game_state));
    check(32'(revive));
    check(32'(keycode_gated));
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (game_state != 3'd2 || revive) cnt++;
    end
    expect_v("held_start_once", 32'd0);
    check(32'(cnt));
    keycode = 8'h07;
    #1;
    expect_v("play_kg_pass", 32'h07);
    check(32'(keycode_gated));
    frame_clk = 1'b1;
    #1;
    expect_v("play_fclk_pass", 32'd1);
    check(32'(frame_clk_gated));
    frame_clk = 1'b0;
    step();

    // Death with three frame ticks.
    fireboy_dead = 1'b1;
    step();
    fireboy_dead = 1'b0;
    expect_v("dying_state", 32'd4);
    expect_v("dying_count", 32'd1);
    expect_v("dying_overlay", 32'd3);
    expect_v("dying_kg", 32'd0);
    check(32'(game_state));
    check(32'(death_count));
    check(32'(overlay_sel));
    check(32'(keycode_gated));
    frame_clk = 1'b1;
    #1;
    expect_v("dying_fclk", 32'd1);
    check(32'(frame_clk_gated));
    frame_clk = 1'b0;
    fpulse();
    fpulse();
    expect_v("dying_after_2", 32'd4);
    check(32'(game_state));
    frame_clk = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (game_state == 3'd1) break;
    end
    expect_v("respawn_start", 32'd1);
    check(32'(game_state));
    step();
    expect_v("respawn_play", 32'd2);
    check(32'(game_state));
    frame_clk = 1'b0;
    step();

    // Both doors reached.
    fireboy_at_door = 1'b1;
    icegirl_at_door = 1'b1;
    step();
    expect_v("win_state", 32'd5);
    expect_v("win_lc_on", 32'd1);
    expect_v("win_overlay", 32'd3);
    check(32'(game_state));
    check(32'(level_complete));
    check(32'(overlay_sel));
    fireboy_at_door = 1'b0;
    icegirl_at_door = 1'b0;
    step();
    expect_v("win_lc_off", 32'd0);
    check(32'(level_complete));
    fpulse();
    expect_v("win_after_1", 32'd5);
    check(32'(game_state));
    frame_clk = 1'b1;
    wait_state(3'd0, 4);
    expect_v("win_to_title", 32'd0);
    expect_v("title_overlay", 32'd1);
    expect_v("win_deaths_held", 32'd1);
    check(32'(game_state));
    check(32'(overlay_sel));
    check(32'(death_count));
    frame_clk = 1'b0;
    step();

    // Pause and resume.
    keycode = 8'h28;
    step();
    step();
    keycode = 8'h29;
    step();
    expect_v("pause_state", 32'd3);
    expect_v("pause_overlay", 32'd2);
    check(32'(game_state));
    check(32'(overlay_sel));
    keycode = 8'h07;
    #1;
    expect_v("pause_kg", 32'd0);
    check(32'(keycode_gated));
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      frame_clk = 1'b1;
      #1;
      if (frame_clk_gated) cnt++;
      step();
      frame_clk = 1'b0;
      step();
    end
    expect_v("pause_fclk_low", 32'd0);
    check(32'(cnt));
    keycode = 8'h28;
    step();
    expect_v("pause_ign_start", 32'd3);
    check(32'(game_state));
    keycode = 8'h29;
    step();
    expect_v("resume_play", 32'd2);
    check(32'(game_state));
    keycode = 8'd0;
    step();

    // Death, doors and pause all at once.
    icegirl_dead = 1'b1;
    fireboy_at_door = 1'b1;
    icegirl_at_door = 1'b1;
    keycode = 8'h29;
    step();
    expect_v("prio_dying", 32'd4);
    expect_v("prio_count", 32'd2);
    check(32'(game_state));
    check(32'(death_count));
    icegirl_dead = 1'b0;
    fireboy_at_door = 1'b0;
    icegirl_at_door = 1'b0;
    keycode = 8'd0;
    repeat (3) fpulse();
    wait_state(3'd2, 8);
    expect_v("prio_back_play", 32'd2);
    check(32'(game_state));

    // Saturation after 256 deaths.
    for (int i = 0; i < 254; i++) die_once();
    expect_v("deaths_sat", 32'd255);
    check(32'(death_count));

    // Reset in the middle of a death.
    fireboy_dead = 1'b1;
    step();
    fireboy_dead = 1'b0;
    expect_v("sat_hold", 32'd255);
    check(32'(death_count));
    fpulse();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    expect_v("mid_rst_state", 32'd0);
    expect_v("mid_rst_deaths", 32'd0);
    expect_v("mid_rst_revive", 32'd1);
    expect_v("mid_rst_overlay", 32'd1);
    check(32'(game_state));
    check(32'(death_count));
    check(32'(revive));
    check(32'(overlay_sel));
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Top-level game sequencer for the FireBoy/IceGirl level. It owns the players' `revive` line and gates their `keycode` and `frame_clk` inputs. It walks the game through title, play, pause, death and win phases based on keyboard presses and player hazard/door flags, and drives overlay selection for the color mapper. Both player controllers and the sprite ROMs sit downstream of it.

## Interface
- `DEATH_FRAMES`, default 60: frame ticks spent in DYING before respawn (1..255).
- `WIN_FRAMES`, default 120: frame ticks spent in WIN before returning to TITLE (1..255).
- `START_KEY`, default 8'h28: keycode that starts the game (Enter).
- `PAUSE_KEY`, default 8'h29: keycode that toggles pause (Esc).

- `Clk`  in  1  system clock; the only clock.
- `Reset`  in  1  synchronous, active-high reset.
- `frame_clk`  in  1  vsync-rate frame clock, sampled on `Clk`.
- `keycode`  in  8  current keyboard keycode.
- `fireboy_dead`, `icegirl_dead`  in  1 each  level hazard flags.
- `fireboy_at_door`, `icegirl_at_door`  in  1 each  player overlaps its exit door.
- `revive`  out  1  reset to both player controllers.
- `keycode_gated`  out  8  keycode forwarded to the players.
- `frame_clk_gated`  out  1  frame clock forwarded to the players.
- `game_state`  out  3  current state encoding.
- `overlay_sel`  out  2  0 = none, 1 = title, 2 = pause, 3 = end banner.
- `death_count`  out  8  deaths this session, saturating.
- `level_complete`  out  1  one-cycle pulse on entry to WIN.

## Operation
- States and encodings: TITLE = 0, START = 1, PLAY = 2, PAUSE = 3, DYING = 4, WIN = 5. Codes 6 and 7 go to TITLE on the next cycle.
- Key press = `keycode` equals the key this cycle and did not equal it last cycle. The previous keycode is held in a register. Holding a key produces only one press.
- `frame_tick` = internal rising-edge detect of `frame_clk`: a delay flop plus a registered edge flag. It is high for exactly one `Clk`, 2 cycles after `frame_clk` rises.
- TITLE:
  - `revive`=1, `keycode_gated`=0, `frame_clk_gated`=0, `overlay_sel`=1.
  - START_KEY press -> START.
- START:
  - Lasts exactly 1 cycle.
  - `revive`=1, gates closed, `overlay_sel`=0.
  - -> PLAY unconditionally.
- PLAY:
  - `revive`=0, `keycode_gated`=`keycode`, `frame_clk_gated`=`frame_clk`, `overlay_sel`=0.
  - Priority, highest first:
    1. `fireboy_dead`|`icegirl_dead` -> DYING.
    2. Else `fireboy_at_door`&`icegirl_at_door` -> WIN.
    3. Else PAUSE_KEY press -> PAUSE.
- PAUSE:
  - `keycode_gated`=0, `frame_clk_gated`=0, `revive`=0, `overlay_sel`=2. Players freeze in place.
  - PAUSE_KEY press -> PLAY.
  - START_KEY is ignored.
- DYING:
  - `keycode_gated`=0, `frame_clk_gated`=`frame_clk`, `overlay_sel`=3.
  - On entry: timer cleared; `death_count` += 1, saturating at 255.
  - Timer counts `frame_tick`. A tick while timer == DEATH_FRAMES-1 -> START, which respawns the players.
  - Dead/door inputs are ignored.
- WIN:
  - Same gating as DYING, `overlay_sel`=3.
  - On entry: timer cleared; `level_complete` high for the first cycle only.
  - A tick while timer == WIN_FRAMES-1 -> TITLE.
  - `death_count` is held.
- Exit from TITLE to START does not clear `death_count`. Only `Reset` clears it.
- Timer is 8 bits. It increments only on `frame_tick` in DYING and WIN, and never wraps within a valid state.

## Timing
- Reset values: state TITLE, `revive`=1, `keycode_gated`=0, `frame_clk_gated`=0, `game_state`=0, `overlay_sel`=1, `death_count`=0, `level_complete`=0, timer 0, previous-keycode register 0, edge flops 0.
- `Reset` asserted mid-operation (any state, mid-timer) returns everything to these values on the next edge.
- State transitions take effect at the `Clk` edge after the qualifying condition.
- `game_state`, `overlay_sel`, `revive` and `frame_clk_gated` gating are decoded combinationally from the state register, so they change together with the state.
- `keycode_gated` is combinational in PLAY: zero latency from `keycode`.
- A key press detected in TITLE puts START on the next edge and PLAY on the edge after. `revive` therefore drops 2 cycles after the press edge.
- DYING lasts exactly DEATH_FRAMES ticks. Cycle count depends on the `frame_clk` phase at entry.
- A death and a door arrival in the same cycle -> DYING. A death and PAUSE_KEY in the same cycle -> DYING.

## Test plan
- Reset, then START_KEY held 10 cycles -> START for 1 cycle, PLAY after; a single `revive` deassertion; no second START.
- In PLAY, pulse `fireboy_dead` 1 cycle with DEATH_FRAMES=3 -> DYING; `death_count`=1; returns to START exactly on the 3rd `frame_tick`; then PLAY.
- In PLAY, assert both door flags -> WIN with `level_complete` high exactly 1 cycle; WIN_FRAMES=2 -> TITLE on the 2nd tick; `overlay_sel`=1.
- In PLAY, press PAUSE_KEY -> PAUSE; `frame_clk_gated` stays 0 over 5 `frame_clk` edges; `keycode_gated`=0 with keycode 8'h07; second press -> PLAY.
- Same cycle: `icegirl_dead`=1, both door flags=1, PAUSE_KEY press -> DYING.
- 256 deaths -> `death_count` saturates at 255. `Reset` asserted midway through DYING -> TITLE and `death_count`=0 next cycle.
